// File: rtl/cc_mux41_arbiter.sv
// cc_mux41_arbiter: round-robin owner scheduler for a shared 4:1 mux.
// Grants are bounded by a quantum and separated by one dead (GAP) cycle.
// Ports:
//   CC_MUXARB_CLOCK_50       clock, rising edge
//   CC_MUXARB_RESET_InLow    async active-low reset
//   CC_MUXARB_request_InBUS  level requests, bit i = requester i
//   CC_MUXARB_select_OutBUS  registered mux select (owner index)
//   CC_MUXARB_grant_OutBUS   registered one-hot grant, zero when no owner
//   CC_MUXARB_valid_Out      high while grant/select name a current owner
//   CC_MUXARB_lock_InBUS     only with CC_MUXARB_LOCK_EN: owner lock bits
// Optional build macro: CC_MUXARB_LOCK_EN (lets a locked owner overrun
// its quantum while its request stays high).
module cc_mux41_arbiter #(
    parameter int MUXARB_SELECTWIDTH = 2,
    parameter int MUXARB_REQWIDTH    = 4,
    parameter int MUXARB_QUANTUM     = 8,
    parameter int MUXARB_CNTWIDTH    = 4
) (
    input  logic                          CC_MUXARB_CLOCK_50,
    input  logic                          CC_MUXARB_RESET_InLow,
    input  logic [MUXARB_REQWIDTH-1:0]    CC_MUXARB_request_InBUS,
    output logic [MUXARB_SELECTWIDTH-1:0] CC_MUXARB_select_OutBUS,
    output logic [MUXARB_REQWIDTH-1:0]    CC_MUXARB_grant_OutBUS,
    output logic                          CC_MUXARB_valid_Out
`ifdef CC_MUXARB_LOCK_EN
    ,
    input  logic [MUXARB_REQWIDTH-1:0]    CC_MUXARB_lock_InBUS
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int SW = MUXARB_SELECTWIDTH;
    localparam int RW = MUXARB_REQWIDTH;
    localparam int CW = MUXARB_CNTWIDTH;
    localparam logic [CW-1:0] QMAX = CW'(MUXARB_QUANTUM - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [RW-1:0]   gnt_q, gnt_d;
    logic            valid_q, valid_d;

    logic [SW-1:0]   win;
    logic [SW-1:0]   idx;
    logic            found;
    logic            any_req;
    logic            own_req;
    logic            others;
    logic            hold_lock;

    // Search starts just after the last-served index, so the previous
    // owner is always considered last.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int k = 1; k <= RW; k++) begin
            idx = ptr_q + SW'(k);
            if (!found && CC_MUXARB_request_InBUS[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign any_req = |CC_MUXARB_request_InBUS;
    assign own_req = CC_MUXARB_request_InBUS[ptr_q];
    // gnt_q is the owner's one-hot while in GRANT
    assign others  = |(CC_MUXARB_request_InBUS & ~gnt_q);

`ifdef CC_MUXARB_LOCK_EN
    assign hold_lock = CC_MUXARB_lock_InBUS[ptr_q] & own_req;
`else
    assign hold_lock = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
                if (any_req) begin
                    state_d    = GRANT;
                    sel_d      = win;
                    ptr_d      = win;
                    gnt_d[win] = 1'b1;
                    valid_d    = 1'b1;
                end
            end
            GRANT: begin
                if (!own_req) begin
                    // owner drop wins over any new request
                    state_d = GAP;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == QMAX) begin
                    if (hold_lock) begin
                        cnt_d = QMAX;
                    end else if (others) begin
                        state_d = GAP;
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        // nobody else waiting: re-arm the quantum
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CC_MUXARB_CLOCK_50 or negedge CC_MUXARB_RESET_InLow) begin
        if (!CC_MUXARB_RESET_InLow) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= SW'(RW - 1);
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign CC_MUXARB_select_OutBUS = sel_q;
    assign CC_MUXARB_grant_OutBUS  = gnt_q;
    assign CC_MUXARB_valid_Out     = valid_q;

endmodule

// File: doc/cc_mux41_arbiter.md
Name: cc_mux41_arbiter

Overview:
- Round-robin scheduler that shares one 4:1 mux datapath between four requesters.
- Drives the mux select bus, plus a one-hot grant and a valid flag back to the requesters.
- Sits between requesting blocks (e.g. sprite/road/score sources) and the shared 4:1 mux.
- Each grant is bounded by a time quantum, and a dead cycle is inserted between owners.

Parameters:
- MUXARB_SELECTWIDTH, 2, width of the select bus driven to the mux.
- MUXARB_REQWIDTH, 4, number of requesters; fixed at 4 in this revision.
- MUXARB_QUANTUM, 8, maximum consecutive cycles per grant when others are waiting; legal range 1..15.
- MUXARB_CNTWIDTH, 4, hold counter width; must satisfy 2^CNTWIDTH > QUANTUM.

Ports:
- CC_MUXARB_CLOCK_50  input  1  system clock, rising edge.
- CC_MUXARB_RESET_InLow  input  1  reset, asynchronous and active-low.
- CC_MUXARB_request_InBUS  input  4  level request per requester; bit i = requester i.
- CC_MUXARB_select_OutBUS  output  2  registered mux select (index of owner).
- CC_MUXARB_grant_OutBUS  output  4  registered one-hot grant; all zero when no owner.
- CC_MUXARB_valid_Out  output  1  high when grant/select reflect a current owner.
- CC_MUXARB_lock_InBUS  input  4  present only with CC_MUXARB_LOCK_EN; bit i extends requester i's grant.

Behaviour:
- All outputs are registered. Reset is asynchronous, active-low, and takes effect immediately, including mid-grant.
- Reset values:
  - select = 0, grant = 0000, valid = 0.
  - state = IDLE, hold counter = 0.
  - last-served pointer = 3, so requester 0 has first priority.
- States: IDLE, GRANT, GAP.
- IDLE:
  - grant = 0000, valid = 0, select holds its last value.
  - If any request bit is high at a clock edge, move to GRANT.
  - The winner is the first requesting index searched from pointer+1 upward, wrapping 3->0.
  - On that edge, set select = winner, grant bit winner = 1, valid = 1, counter = 0, pointer = winner.
  - Latency: request seen at edge N gives grant visible after edge N (one cycle).
- GRANT:
  - The counter increments every cycle and saturates at QUANTUM-1.
  - Exit to GAP at the edge where the owner's request is low.
  - Also exit to GAP at the edge where counter = QUANTUM-1 and any other request is high.
  - If counter = QUANTUM-1 and no other request is pending, stay in GRANT, reset counter to 0, keep the owner.
  - If the owner's request drops and another request rises on the same edge, the drop wins: go to GAP.
- GAP:
  - Lasts exactly one cycle: grant = 0000, valid = 0, select holds the previous owner (break-before-make, no select glitch).
  - Next edge: if any request is high, arbitrate as in IDLE and go to GRANT; otherwise go to IDLE.
  - The previous owner is searched last, because pointer = previous owner.
- Requests arriving during GAP are sampled at the GAP-exit edge.
- grant is always zero or one-hot. valid == |grant. When valid = 1, select equals the index of the set grant bit.
- Request bits never set in the future are never granted. No starvation: any held request is granted within 3*(QUANTUM+1) cycles.

Optional Feature:
- Macro: CC_MUXARB_LOCK_EN.
- Defined:
  - CC_MUXARB_lock_InBUS exists.
  - While in GRANT with lock[owner] = 1 and request[owner] = 1, the quantum exit is suppressed; the counter stays saturated at QUANTUM-1.
  - Exit to GAP occurs only when the owner's request drops, or at the first edge with lock[owner] = 0 and another request pending.
  - Lock bits of non-owners are ignored.
- Undefined: the port is absent and behaviour is pure round-robin with quantum, as above.

Test Plan:
- Reset then request = 0001 held -> after 1 edge grant = 0001, select = 0, valid = 1. Grant persists indefinitely; counter re-arms every 8 cycles with no GAP.
- request = 1111 held, QUANTUM = 8 -> owners 0,1,2,3,0 in order. Each holds exactly 8 valid cycles, followed by 1 GAP cycle with valid = 0 and select unchanged.
- Owner 2 granted; drop request[2] after 3 cycles while request = 1001 -> GAP next cycle, then grant requester 3 (rotation after 2), then requester 0.
- Mid-grant, assert reset low asynchronously (between edges) -> outputs 0 / 0000 / 0 immediately. After release with request = 0110 -> requester 1 granted first.
- Random request toggling for 10k cycles, checked every cycle:
  - grant is zero or one-hot, valid == |grant, select == index(grant) when valid.
  - No requester waits beyond 27 cycles.
- With CC_MUXARB_LOCK_EN: owner 1, lock = 0010, request = 1111 -> requester 1 holds beyond 8 cycles. Clear lock[1] -> GAP on the next edge, then requester 2 granted.
